// File: rtl/snf_sram_pkg.sv
// Shared definitions for the SNF SRAM arbiter: default widths, grant encoding
// and the width of the performance counters.
package snf_sram_pkg;

   localparam int unsigned ADDR_W_DEF    = 44;
   localparam int unsigned DATA_W_DEF    = 512;
   localparam int unsigned IDX_W_DEF     = 2;
   localparam int unsigned RSP_DEPTH_DEF = 2;
   localparam int unsigned PERF_W        = 32;

   // Which requester owns the SRAM port in the current cycle
   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_WR   = 2'd1,
      GNT_RD   = 2'd2
   } gnt_e;

endpackage

// File: rtl/snf_sram_rsp_fifo.sv
// Read-response FIFO: DEPTH x DATA_W synchronous FIFO with occupancy count.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   i_push        write i_push_data (caller guarantees not full)
//   i_pop         consume head entry (ignored when empty)
//   o_valid       FIFO not empty
//   o_data        head entry
//   o_count       number of stored entries
module snf_sram_rsp_fifo #(
   parameter int unsigned DEPTH  = 2,
   parameter int unsigned DATA_W = 512
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic [DATA_W-1:0]        i_push_data,
   input  logic                     i_pop,
   output logic                     o_valid,
   output logic [DATA_W-1:0]        o_data,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [PTR_W:0]    r_cnt;
   logic              w_pop;

   assign w_pop   = i_pop & (r_cnt != '0);
   assign o_valid = (r_cnt != '0);
   assign o_data  = r_mem[r_rd_ptr];
   assign o_count = r_cnt;

   // Storage array, no reset needed: entries are only read when counted valid
   always_ff @(posedge clk) begin
      if (i_push) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

   // Pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({i_push, w_pop})
            2'b10:   r_cnt <= r_cnt + (PTR_W+1)'(1);
            2'b01:   r_cnt <= r_cnt - (PTR_W+1)'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: rtl/snf_sram_arb.sv
// Arbiter/sequencer sharing one single-port SRAM between a write and a read
// requester. One access per cycle, round-robin with write priority on an
// index hazard, 1-cycle read latency absorbed by a credit-checked response FIFO.
// Optional macro SNF_SRAM_ARB_PERF_EN adds saturating perf counters.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   i_wr_req_*/o_wr_req_ready     write request channel (ready == grant)
//   i_rd_req_*/o_rd_req_ready     read request channel (ready == grant)
//   o_rd_rsp_*/i_rd_rsp_ready     read response channel (FIFO head)
//   o_sram_*/i_sram_rd_data       SRAM port
//   i_sram_full                   SRAM full indication
//   o_err_overflow                sticky: write issued while SRAM full
//   o_perf_*_cnt                  (SNF_SRAM_ARB_PERF_EN only) grant/stall counters
module snf_sram_arb
   import snf_sram_pkg::*;
#(
   parameter int unsigned ADDR_W    = ADDR_W_DEF,
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned IDX_W     = IDX_W_DEF,
   parameter int unsigned RSP_DEPTH = RSP_DEPTH_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_wr_req_valid,
   output logic              o_wr_req_ready,
   input  logic [ADDR_W-1:0] i_wr_req_addr,
   input  logic [DATA_W-1:0] i_wr_req_data,
   input  logic              i_rd_req_valid,
   output logic              o_rd_req_ready,
   input  logic [ADDR_W-1:0] i_rd_req_addr,
   output logic              o_rd_rsp_valid,
   input  logic              i_rd_rsp_ready,
   output logic [DATA_W-1:0] o_rd_rsp_data,
   output logic [ADDR_W-1:0] o_sram_addr,
   output logic              o_sram_wr_en,
   output logic [DATA_W-1:0] o_sram_wr_data,
   output logic              o_sram_rd_en,
   input  logic [DATA_W-1:0] i_sram_rd_data,
   input  logic              i_sram_full,
   output logic              o_err_overflow
`ifdef SNF_SRAM_ARB_PERF_EN
   ,
   output logic [PERF_W-1:0] o_perf_wr_cnt,
   output logic [PERF_W-1:0] o_perf_rd_cnt,
   output logic [PERF_W-1:0] o_perf_stall_cnt
`else
   // perf counter ports absent
`endif
);

   localparam int unsigned CNT_W = $clog2(RSP_DEPTH) + 1;

   gnt_e             r_rr_last;
   logic             r_rd_inflight;
   logic             r_err_overflow;
   gnt_e             w_gnt;
   logic [CNT_W-1:0] w_fifo_cnt;
   logic [CNT_W-1:0] w_occ;
   logic             w_pop;
   logic             w_rd_elig;
   logic             w_wr_elig;
   logic             w_hazard;

   // Credit check: entries held after this cycle's pop plus the read in flight
   assign w_pop     = o_rd_rsp_valid & i_rd_rsp_ready;
   assign w_occ     = w_fifo_cnt - CNT_W'(w_pop) + CNT_W'(r_rd_inflight);
   assign w_rd_elig = ~rst & i_rd_req_valid & (w_occ < CNT_W'(RSP_DEPTH));
   assign w_wr_elig = ~rst & i_wr_req_valid;
   assign w_hazard  = (i_wr_req_addr[IDX_W-1:0] == i_rd_req_addr[IDX_W-1:0]);

   // Grant select: round-robin, write forced first when both hit the same entry
   always_comb begin
      w_gnt = GNT_NONE;
      if (w_wr_elig && w_rd_elig) begin
         w_gnt = (w_hazard || (r_rr_last == GNT_RD)) ? GNT_WR : GNT_RD;
      end else if (w_wr_elig) begin
         w_gnt = GNT_WR;
      end else if (w_rd_elig) begin
         w_gnt = GNT_RD;
      end
   end

   // SRAM port driven straight from the grant; idle port holds zeros
   always_comb begin
      o_sram_addr    = '0;
      o_sram_wr_data = '0;
      o_sram_wr_en   = 1'b0;
      o_sram_rd_en   = 1'b0;
      case (w_gnt)
         GNT_WR: begin
            o_sram_addr    = i_wr_req_addr;
            o_sram_wr_data = i_wr_req_data;
            o_sram_wr_en   = 1'b1;
         end
         GNT_RD: begin
            o_sram_addr  = i_rd_req_addr;
            o_sram_rd_en = 1'b1;
         end
         default: ;
      endcase
   end

   assign o_wr_req_ready = (w_gnt == GNT_WR);
   assign o_rd_req_ready = (w_gnt == GNT_RD);
   assign o_err_overflow = r_err_overflow;

   // Arbitration history, read pipeline stage and overflow flag
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr_last      <= GNT_WR;
         r_rd_inflight  <= 1'b0;
         r_err_overflow <= 1'b0;
      end else begin
         if (w_gnt != GNT_NONE) r_rr_last <= w_gnt;
         r_rd_inflight  <= (w_gnt == GNT_RD);
         r_err_overflow <= r_err_overflow | (o_sram_wr_en & i_sram_full);
      end
   end

   snf_sram_rsp_fifo #(
      .DEPTH  (RSP_DEPTH),
      .DATA_W (DATA_W)
   ) u_rsp_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_push      (r_rd_inflight),
      .i_push_data (i_sram_rd_data),
      .i_pop       (w_pop),
      .o_valid     (o_rd_rsp_valid),
      .o_data      (o_rd_rsp_data),
      .o_count     (w_fifo_cnt)
   );

`ifdef SNF_SRAM_ARB_PERF_EN
   logic r_unused_perf;
   logic w_stall;

   assign w_stall = (i_wr_req_valid & ~o_wr_req_ready) | (i_rd_req_valid & ~o_rd_req_ready);

   // Saturating event counters
   always_ff @(posedge clk) begin
      if (rst) begin
         o_perf_wr_cnt    <= '0;
         o_perf_rd_cnt    <= '0;
         o_perf_stall_cnt <= '0;
      end else begin
         if (o_wr_req_ready && (o_perf_wr_cnt != '1))
            o_perf_wr_cnt <= o_perf_wr_cnt + PERF_W'(1);
         if (o_rd_req_ready && (o_perf_rd_cnt != '1))
            o_perf_rd_cnt <= o_perf_rd_cnt + PERF_W'(1);
         if (w_stall && (o_perf_stall_cnt != '1))
            o_perf_stall_cnt <= o_perf_stall_cnt + PERF_W'(1);
      end
   end
`else
   // no performance counters in this build
`endif

endmodule

// File: tb/tb_snf_sram_arb.sv
// Directed bench for snf_sram_arb with a 4-entry behavioural SRAM.
module tb_snf_sram_arb;

   localparam logic [511:0] D_A5 = {64{8'hA5}};
   localparam logic [511:0] D_11 = {64{8'h11}};
   localparam logic [511:0] D_5A = {64{8'h5A}};
   localparam logic [511:0] D_C3 = {64{8'hC3}};

   logic         clk = 1'b0;
   logic         rst;
   logic         wr_req_valid, wr_req_ready;
   logic [43:0]  wr_req_addr;
   logic [511:0] wr_req_data;
   logic         rd_req_valid, rd_req_ready;
   logic [43:0]  rd_req_addr;
   logic         rd_rsp_valid, rd_rsp_ready;
   logic [511:0] rd_rsp_data;
   logic [43:0]  sram_addr;
   logic         sram_wr_en, sram_rd_en;
   logic [511:0] sram_wr_data;
   logic [511:0] sram_rd_data;
   logic         sram_full;
   logic         err_overflow;
`ifdef SNF_SRAM_ARB_PERF_EN
   logic [31:0]  perf_wr_cnt, perf_rd_cnt, perf_stall_cnt;
`endif

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   snf_sram_arb dut (
      .clk            (clk),
      .rst            (rst),
      .i_wr_req_valid (wr_req_valid),
      .o_wr_req_ready (wr_req_ready),
      .i_wr_req_addr  (wr_req_addr),
      .i_wr_req_data  (wr_req_data),
      .i_rd_req_valid (rd_req_valid),
      .o_rd_req_ready (rd_req_ready),
      .i_rd_req_addr  (rd_req_addr),
      .o_rd_rsp_valid (rd_rsp_valid),
      .i_rd_rsp_ready (rd_rsp_ready),
      .o_rd_rsp_data  (rd_rsp_data),
      .o_sram_addr    (sram_addr),
      .o_sram_wr_en   (sram_wr_en),
      .o_sram_wr_data (sram_wr_data),
      .o_sram_rd_en   (sram_rd_en),
      .i_sram_rd_data (sram_rd_data),
      .i_sram_full    (sram_full),
      .o_err_overflow (err_overflow)
`ifdef SNF_SRAM_ARB_PERF_EN
      ,
      .o_perf_wr_cnt    (perf_wr_cnt),
      .o_perf_rd_cnt    (perf_rd_cnt),
      .o_perf_stall_cnt (perf_stall_cnt)
`endif
   );

   // Behavioural SRAM: 4 entries, read data one cycle after the strobe
   logic [511:0] sram_mem [4];
   always @(posedge clk) begin
      if (sram_wr_en) sram_mem[sram_addr[1:0]] <= sram_wr_data;
      if (sram_rd_en) sram_rd_data <= sram_mem[sram_addr[1:0]];
   end

   task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_req_valid = 1'b0;
      wr_req_addr  = '0;
      wr_req_data  = '0;
      rd_req_valid = 1'b0;
      rd_req_addr  = '0;
   endtask

   initial begin
      logic [1:0] exp_alt [4];
      logic       exp_bp  [4];

      for (int i = 0; i < 4; i++) sram_mem[i] = '0;
      sram_rd_data = '0;
      idle();
      rd_rsp_ready = 1'b0;
      sram_full    = 1'b0;
      rst          = 1'b1;
      wr_req_valid = 1'b1;
      rd_req_valid = 1'b1;

      // Reset state, grants suppressed while rst is high
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_wr_ready", 512'(wr_req_ready), 512'(0));
      chk("rst_rd_ready", 512'(rd_req_ready), 512'(0));
      chk("rst_sram_en",  512'({sram_wr_en, sram_rd_en}), 512'(0));
      chk("rst_rsp_vld",  512'(rd_rsp_valid), 512'(0));
      chk("rst_err",      512'(err_overflow), 512'(0));
      tick();
      rst = 1'b0;
      idle();

      // Write only
      wr_req_valid = 1'b1; wr_req_addr = 44'd1; wr_req_data = D_A5;
      @(negedge clk);
      chk("wr_ready",   512'(wr_req_ready), 512'(1));
      chk("wr_en",      512'(sram_wr_en),   512'(1));
      chk("wr_rd_idle", 512'({rd_req_ready, sram_rd_en}), 512'(0));
      chk("wr_addr",    512'(sram_addr),    512'(1));
      chk("wr_data",    sram_wr_data,       D_A5);
      tick();

      // Read back address 1
      idle();
      rd_rsp_ready = 1'b1;
      rd_req_valid = 1'b1; rd_req_addr = 44'd1;
      @(negedge clk);
      chk("rd_ready",   512'(rd_req_ready), 512'(1));
      chk("rd_en",      512'({sram_wr_en, sram_rd_en}), 512'(1));
      chk("rd_addr",    512'(sram_addr),    512'(1));
      tick();
      idle();
      @(negedge clk);
      chk("rd_lat_n1",  512'(rd_rsp_valid), 512'(0));
      tick();
      @(negedge clk);
      chk("rd_lat_n2",  512'(rd_rsp_valid), 512'(1));
      chk("rd_data",    rd_rsp_data,        D_A5);
      tick();
      @(negedge clk);
      chk("rd_popped",  512'(rd_rsp_valid), 512'(0));

      // Round-robin after reset: read favoured first
      rst = 1'b1;
      tick();
      rst = 1'b0;
      wr_req_valid = 1'b1; wr_req_addr = 44'd0; wr_req_data = D_11;
      rd_req_valid = 1'b1; rd_req_addr = 44'd3;
      exp_alt[0] = 2'b01; exp_alt[1] = 2'b10; exp_alt[2] = 2'b01; exp_alt[3] = 2'b10;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("alt_gnt%0d", i), 512'({wr_req_ready, rd_req_ready}), 512'(exp_alt[i]));
         chk($sformatf("alt_excl%0d", i), 512'(sram_wr_en & sram_rd_en), 512'(0));
         tick();
      end
      idle();
      repeat (3) tick();

      // Same-index hazard: write wins although read is due
      wr_req_valid = 1'b1; wr_req_addr = 44'd2; wr_req_data = D_5A;
      rd_req_valid = 1'b1; rd_req_addr = 44'd6;
      @(negedge clk);
      chk("haz_gnt0", 512'({wr_req_ready, rd_req_ready}), 512'(2'b10));
      tick();
      wr_req_valid = 1'b0;
      @(negedge clk);
      chk("haz_gnt1", 512'({wr_req_ready, rd_req_ready}), 512'(2'b01));
      tick();
      idle();
      tick();
      @(negedge clk);
      chk("haz_vld",  512'(rd_rsp_valid), 512'(1));
      chk("haz_data", rd_rsp_data,        D_5A);
      tick();

      // Response back-pressure: only two reads accepted
      rd_rsp_ready = 1'b0;
      rd_req_valid = 1'b1; rd_req_addr = 44'd1;
      exp_bp[0] = 1'b1; exp_bp[1] = 1'b1; exp_bp[2] = 1'b0; exp_bp[3] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("bp_gnt%0d", i), 512'(rd_req_ready), 512'(exp_bp[i]));
         tick();
      end
      @(negedge clk);
      chk("bp_full_vld", 512'(rd_rsp_valid), 512'(1));
      rd_rsp_ready = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
      // cycle after release: pop frees a credit, read resumes
      // (the edge above consumed the wait; re-evaluate the new cycle)
      @(negedge clk);
      chk("bp_resume", 512'(rd_req_ready), 512'(1));
      chk("bp_data",   rd_rsp_data,        D_A5);
      tick();
      idle();
      repeat (2) tick();
      @(negedge clk);
      chk("bp_drained", 512'(rd_rsp_valid), 512'(0));
      tick();

      // Overflow on 4th write, sticky afterwards
      for (int i = 0; i < 4; i++) begin
         wr_req_valid = 1'b1; wr_req_addr = 44'(i); wr_req_data = D_C3;
         sram_full = (i == 3);
         @(negedge clk);
         chk($sformatf("ovf_err_pre%0d", i), 512'(err_overflow), 512'(0));
         chk($sformatf("ovf_wr_en%0d", i),   512'(sram_wr_en),   512'(1));
         tick();
      end
      idle();
      sram_full = 1'b0;
      @(negedge clk);
      chk("ovf_set", 512'(err_overflow), 512'(1));
      tick();
      @(negedge clk);
      chk("ovf_sticky", 512'(err_overflow), 512'(1));

      // Reset while a read is in flight: response dropped
      rd_req_valid = 1'b1; rd_req_addr = 44'd1;
      @(negedge clk);
      chk("rmid_gnt", 512'(rd_req_ready), 512'(1));
      tick();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rmid_err_clr", 512'(err_overflow), 512'(0));
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rmid_no_rsp%0d", i), 512'(rd_rsp_valid), 512'(0));
         tick();
         @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
